// File: rtl/painterengine_gpu_dma_pkg.sv
// PainterEngine GPU read DMA: shared types and AXI constants.
// State and error encodings used by the reader and its router.
package painterengine_gpu_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    ERR_OK         = 3'd0,
    ERR_ROUTER     = 3'd1,
    ERR_PARAM      = 3'd2,
    ERR_AR_TIMEOUT = 3'd3,
    ERR_R_TIMEOUT  = 3'd4,
    ERR_PROTOCOL   = 3'd5,
    ERR_SLVERR     = 3'd6
  } err_t;

  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [3:0] ARCACHE_DEF  = 4'b0010;
  localparam logic [1:0] RRESP_OKAY   = 2'b00;

  function automatic logic [2:0] ar_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_reader_mc_route.sv
// Steers R beats to the latched consumer channel and
// returns that channel's ready as RREADY.
module painterengine_gpu_dma_route
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           enable,
  input  logic [$clog2(CHANNELS)-1:0]    channel,
  input  logic [DATA_WIDTH-1:0]          rdata,
  input  logic                           rvalid,
  input  logic [CHANNELS-1:0]            data_next,
  output logic [CHANNELS*DATA_WIDTH-1:0] data,
  output logic [CHANNELS-1:0]            data_valid,
  output logic                           rready
);

  localparam int CW = $clog2(CHANNELS);

  always_comb begin
    data       = '0;
    data_valid = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (enable && channel == CW'(i)) begin
        data[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
        data_valid[i] = rvalid;
      end
    end
  end

  assign rready = enable & data_next[channel];

endmodule

// File: rtl/painterengine_gpu_dma_reader_mc.sv
// Multi-channel AXI4 read DMA: one transfer at a time,
// split into bursts that never cross a MAX_BURST boundary.
module painterengine_gpu_dma_reader_mc
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 32,
  parameter int MAX_BURST      = 256,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic                           i_wire_clock,
  input  logic                           i_wire_resetn,
  input  logic                           i_wire_start,
  input  logic [CHANNELS-1:0]            i_wire_router,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] i_wire_address,
  input  logic [CHANNELS*LEN_WIDTH-1:0]  i_wire_length,
  output logic                           o_wire_busy,
  output logic                           o_wire_done,
  output logic                           o_wire_error,
  output logic [2:0]                     o_wire_error_type,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_wire_data,
  output logic [CHANNELS-1:0]            o_wire_data_valid,
  input  logic [CHANNELS-1:0]            i_wire_data_next,
  output logic                           o_wire_M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]          o_wire_M_AXI_ARADDR,
  output logic [7:0]                     o_wire_M_AXI_ARLEN,
  output logic [2:0]                     o_wire_M_AXI_ARSIZE,
  output logic [1:0]                     o_wire_M_AXI_ARBURST,
  output logic                           o_wire_M_AXI_ARLOCK,
  output logic [3:0]                     o_wire_M_AXI_ARCACHE,
  output logic [2:0]                     o_wire_M_AXI_ARPROT,
  output logic [3:0]                     o_wire_M_AXI_ARQOS,
  output logic                           o_wire_M_AXI_ARVALID,
  input  logic                           i_wire_M_AXI_ARREADY,
  input  logic                           i_wire_M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]          i_wire_M_AXI_RDATA,
  input  logic [1:0]                     i_wire_M_AXI_RRESP,
  input  logic                           i_wire_M_AXI_RLAST,
  input  logic                           i_wire_M_AXI_RVALID,
  output logic                           o_wire_M_AXI_RREADY
);

  localparam int CW  = $clog2(CHANNELS);
  localparam int SZ  = $clog2(DATA_WIDTH / 8);
  localparam int MBW = $clog2(MAX_BURST);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW  = LEN_WIDTH + 1;

  state_t                state;
  err_t                  err;
  logic [CW-1:0]         chan;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  offset;
  logic [LW-1:0]         burst;
  logic [LW-1:0]         beat_cnt;
  logic [TW-1:0]         tmo;

  logic [CW-1:0]         sel_idx;
  logic [MBW-1:0]        beat_idx;
  logic [LW-1:0]         remain;
  logic [LW-1:0]         room;
  logic [LW-1:0]         burst_calc;
  logic [ADDR_WIDTH-1:0] araddr_calc;
  logic [LEN_WIDTH-1:0]  offset_next;
  logic [LW-1:0]         beat_next;
  logic                  rready;
  logic                  rx_hs;
  logic                  tmo_hit;
  logic                  last_beat;
  logic                  unused_rid;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_wire_router[i]) sel_idx = CW'(i);
    end
  end

  // Burst length: stop at the transfer end or the aligned boundary
  assign beat_idx    = MBW'(addr >> SZ) + MBW'(offset);
  assign remain      = {1'b0, len} - {1'b0, offset};
  assign room        = LW'(MAX_BURST) - LW'(beat_idx);
  assign burst_calc  = (remain < room) ? remain : room;
  assign araddr_calc = addr + (ADDR_WIDTH'(offset) << SZ);
  assign offset_next = offset + burst[LEN_WIDTH-1:0];
  assign beat_next   = beat_cnt + LW'(1);
  assign last_beat   = (beat_next == burst);
  assign rx_hs       = i_wire_M_AXI_RVALID & rready;
  assign tmo_hit     = (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign unused_rid  = i_wire_M_AXI_RID;

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state                <= ST_IDLE;
      err                  <= ERR_OK;
      chan                 <= '0;
      addr                 <= '0;
      len                  <= '0;
      offset               <= '0;
      burst                <= '0;
      beat_cnt             <= '0;
      tmo                  <= '0;
      o_wire_M_AXI_ARVALID <= 1'b0;
      o_wire_M_AXI_ARADDR  <= '0;
      o_wire_M_AXI_ARLEN   <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_wire_start) begin
            chan   <= sel_idx;
            addr   <= i_wire_address[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            len    <= i_wire_length[sel_idx*LEN_WIDTH +: LEN_WIDTH];
            offset <= '0;
            tmo    <= '0;
            if ($onehot(i_wire_router)) begin
              state <= ST_CHECK;
              err   <= ERR_OK;
            end else begin
              state <= ST_ERROR;
              err   <= ERR_ROUTER;
            end
          end
        end
        ST_CHECK: begin
          if (addr[SZ-1:0] != '0 || len == '0) begin
            state <= ST_ERROR;
            err   <= ERR_PARAM;
          end else begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          burst                <= burst_calc;
          beat_cnt             <= '0;
          tmo                  <= '0;
          o_wire_M_AXI_ARADDR  <= araddr_calc;
          o_wire_M_AXI_ARLEN   <= 8'(burst_calc - LW'(1));
          o_wire_M_AXI_ARVALID <= 1'b1;
          state                <= ST_ADDR;
        end
        ST_ADDR: begin
          if (i_wire_M_AXI_ARREADY) begin
            o_wire_M_AXI_ARVALID <= 1'b0;
            beat_cnt             <= '0;
            tmo                  <= '0;
            state                <= ST_DATA;
          end else if (tmo_hit) begin
            o_wire_M_AXI_ARVALID <= 1'b0;
            tmo                  <= '0;
            state                <= ST_ERROR;
            err                  <= ERR_AR_TIMEOUT;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        ST_DATA: begin
          if (rx_hs) begin
            beat_cnt <= beat_next;
            tmo      <= '0;
            if (i_wire_M_AXI_RRESP != RRESP_OKAY) begin
              state <= ST_ERROR;
              err   <= ERR_SLVERR;
            end else if (i_wire_M_AXI_RLAST != last_beat) begin
              state <= ST_ERROR;
              err   <= ERR_PROTOCOL;
            end else if (last_beat) begin
              offset <= offset_next;
              state  <= (offset_next == len) ? ST_DONE : ST_CALC;
            end
          end else if (!i_wire_M_AXI_RVALID) begin
            if (tmo_hit) begin
              tmo   <= '0;
              state <= ST_ERROR;
              err   <= ERR_R_TIMEOUT;
            end else begin
              tmo <= tmo + TW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_wire_busy = state inside {ST_CHECK, ST_CALC, ST_ADDR, ST_DATA};
  assign o_wire_done       = (state == ST_DONE);
  assign o_wire_error      = (state == ST_ERROR);
  assign o_wire_error_type = err;

  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARSIZE  = ar_size(DATA_WIDTH);
  assign o_wire_M_AXI_ARBURST = ARBURST_INCR;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = ARCACHE_DEF;
  assign o_wire_M_AXI_ARPROT  = 3'b000;
  assign o_wire_M_AXI_ARQOS   = 4'b0000;
  assign o_wire_M_AXI_RREADY  = rready;

  painterengine_gpu_dma_route #(
    .CHANNELS   (CHANNELS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_route (
    .enable     (state == ST_DATA),
    .channel    (chan),
    .rdata      (i_wire_M_AXI_RDATA),
    .rvalid     (i_wire_M_AXI_RVALID),
    .data_next  (i_wire_data_next),
    .data       (o_wire_data),
    .data_valid (o_wire_data_valid),
    .rready     (rready)
  );

endmodule
